aes_gcm_ctr_stage: RTL

Pipeline stage 3 of the AES-GCM datapath, directly downstream of the H/J0 stage. It takes the per-block stream (plaintext or AAD block, instance size, H, J0, key schedule) and tracks each GCM instance with a small FSM. For every plaintext block it produces the counter block inc32(J0, n), along with a byte-exact valid-bit mask for the final partial block. After the last block of an instance it inserts the GHASH length block. All outputs are registered, and the stage feeds the CTR-encrypt and GHASH stages.

---
 rtl/aes_gcm_pkg.sv | 30 +++
 rtl/aes_gcm_mask_gen.sv | 13 +
 rtl/aes_gcm_ctr_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/aes_gcm_pkg.sv
// Shared types and helpers for the AES-GCM datapath stages.
package aes_gcm_pkg;

    localparam int BLOCK_W = 128;
    localparam int KS_W    = 1408;
    localparam int LEN_W   = 64;
    localparam int CNT_W   = 65;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LEN  = 2'd2
    } state_t;

    // GCM inc32: add n to the low 32 bits, leave the upper 96 untouched.
    function automatic logic [0:BLOCK_W-1] fn_inc32(input logic [0:BLOCK_W-1] block,
                                                    input logic [31:0]        n);
        fn_inc32 = {block[0:95], block[96:127] + n};
    endfunction

    // r leading ones then zeros; r = 0 means a full block.
    function automatic logic [0:BLOCK_W-1] fn_len_mask(input logic [6:0] r);
        if (r == 7'd0) begin
            fn_len_mask = {BLOCK_W{1'b1}};
        end else begin
            fn_len_mask = ~({BLOCK_W{1'b1}} >> r);
        end
    endfunction

endpackage

// File: rtl/aes_gcm_mask_gen.sv
// Block count (ceil(len/128)) and final-block bit mask from a 64-bit bit length.
module aes_gcm_mask_gen
    import aes_gcm_pkg::*;
(
    input  logic [LEN_W-1:0]   len,
    output logic [CNT_W-1:0]   blocks,
    output logic [0:BLOCK_W-1] last_mask
);

    assign blocks    = ({1'b0, len} + CNT_W'(127)) >> 7;
    assign last_mask = fn_len_mask(len[6:0]);

endmodule

// File: rtl/aes_gcm_ctr_stage.sv
// AES-GCM stage 3: per-instance tracking, CTR block generation, tail masks, GHASH length block.
// Optional protocol checking is built when AES_GCM_LEN_CHECK_EN is defined.
module aes_gcm_ctr_stage
    import aes_gcm_pkg::*;
#(
    parameter int CTR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_new_instance,
    input  logic                i_pt_instance,
    input  logic [0:BLOCK_W-1]  i_plain_text,
    input  logic [0:BLOCK_W-1]  i_aad,
    input  logic [0:BLOCK_W-1]  i_instance_size,
    input  logic [0:BLOCK_W-1]  i_h,
    input  logic [0:BLOCK_W-1]  i_j0,
    input  logic [0:KS_W-1]     i_key_schedule,
    output logic                o_valid,
    output logic                o_is_pt,
    output logic [0:BLOCK_W-1]  o_block,
    output logic [0:BLOCK_W-1]  o_ctr_block,
    output logic [0:BLOCK_W-1]  o_mask,
    output logic                o_len_valid,
    output logic [0:BLOCK_W-1]  o_len_block,
    output logic [0:BLOCK_W-1]  o_h,
    output logic [0:BLOCK_W-1]  o_j0,
    output logic [0:KS_W-1]     o_key_schedule,
    output logic                o_err
);

    // Handshake: a beat transfers on a rising edge where i_valid & o_ready;
    // o_ready is registered and low only during the LEN state.
    state_t               st_q, st_d;
    logic                 ready_q;
    logic [0:BLOCK_W-1]   j0_q, h_q, size_q;
    logic [0:KS_W-1]      ks_q;
    logic [CTR_W-1:0]     ctr_q, ctr_cur, ctr_nxt;
    logic [CNT_W-1:0]     aad_rem_q, pt_rem_q, aad_cur, pt_cur, aad_nxt, pt_nxt;
    logic [CNT_W-1:0]     a_blocks, c_blocks;
    logic [0:BLOCK_W-1]   size_cur, j0_cur, ctr_blk, a_mask, c_mask, mask_cur;
    logic                 acc, is_new, zero_len, drop, do_data;

    assign acc      = i_valid & ready_q;
    assign is_new   = acc & i_new_instance;
    assign size_cur = is_new ? i_instance_size : size_q;
    assign j0_cur   = is_new ? i_j0 : j0_q;
    assign ctr_cur  = is_new ? i_j0[BLOCK_W-CTR_W:BLOCK_W-1] : ctr_q;

    aes_gcm_mask_gen u_mask_a (.len(size_cur[0:63]),   .blocks(a_blocks), .last_mask(a_mask));
    aes_gcm_mask_gen u_mask_c (.len(size_cur[64:127]), .blocks(c_blocks), .last_mask(c_mask));

    assign aad_cur  = is_new ? a_blocks : aad_rem_q;
    assign pt_cur   = is_new ? c_blocks : pt_rem_q;
    assign zero_len = is_new & (a_blocks == '0) & (c_blocks == '0);

    generate
        if (CTR_W == 32) begin : g_inc32
            assign ctr_blk = fn_inc32({j0_cur[0:95], ctr_cur}, 32'd1);
        end else begin : g_incn
            assign ctr_blk = {j0_cur[0:BLOCK_W-1-CTR_W], ctr_cur + CTR_W'(1)};
        end
    endgenerate
    assign ctr_nxt = ctr_blk[BLOCK_W-CTR_W:BLOCK_W-1];

`ifdef AES_GCM_LEN_CHECK_EN
    logic bad_data, err_set, err_q;
    assign bad_data = (i_pt_instance ? ((pt_cur == '0) | (aad_cur != '0)) : (aad_cur == '0))
                    | ((st_q == ST_IDLE) & ~i_new_instance);
    assign drop     = acc & ~zero_len & bad_data;
    // Restarting mid-instance is flagged but the new instance still takes over.
    assign err_set  = acc & ((bad_data & ~zero_len) | (i_new_instance & (st_q == ST_RUN)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
    assign o_err = err_q;
`else
    assign drop  = 1'b0;
    assign o_err = 1'b0;
`endif

    assign do_data = acc & ~zero_len & ~drop;

    always_comb begin
        aad_nxt  = aad_cur;
        pt_nxt   = pt_cur;
        mask_cur = {BLOCK_W{1'b1}};
        st_d     = st_q;
        if (do_data) begin
            if (i_pt_instance) begin
                if (pt_cur != '0) pt_nxt = pt_cur - CNT_W'(1);
                if (pt_cur == CNT_W'(1)) mask_cur = c_mask;
            end else begin
                if (aad_cur != '0) aad_nxt = aad_cur - CNT_W'(1);
                if (aad_cur == CNT_W'(1)) mask_cur = a_mask;
            end
        end
        case (st_q)
            ST_LEN: st_d = ST_IDLE;
            default: begin
                if (acc && !drop) begin
                    if ((aad_nxt == '0) && (pt_nxt == '0) &&
                        (is_new || (aad_cur != '0) || (pt_cur != '0))) begin
                        st_d = ST_LEN;
                    end else if (is_new) begin
                        st_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= ST_IDLE;
            ready_q     <= 1'b0;
            j0_q        <= '0;
            h_q         <= '0;
            size_q      <= '0;
            ks_q        <= '0;
            ctr_q       <= '0;
            aad_rem_q   <= '0;
            pt_rem_q    <= '0;
            o_valid     <= 1'b0;
            o_is_pt     <= 1'b0;
            o_block     <= '0;
            o_ctr_block <= '0;
            o_mask      <= '0;
            o_len_valid <= 1'b0;
            o_len_block <= '0;
        end else begin
            st_q    <= st_d;
            ready_q <= (st_d != ST_LEN);
            if (is_new) begin
                j0_q   <= i_j0;
                h_q    <= i_h;
                ks_q   <= i_key_schedule;
                size_q <= i_instance_size;
            end
            if (acc && !drop) begin
                aad_rem_q <= aad_nxt;
                pt_rem_q  <= pt_nxt;
                ctr_q     <= (do_data && i_pt_instance) ? ctr_nxt : ctr_cur;
            end
            o_valid     <= do_data;
            o_is_pt     <= do_data & i_pt_instance;
            o_block     <= do_data ? (i_pt_instance ? i_plain_text : i_aad) : '0;
            o_ctr_block <= (do_data && i_pt_instance) ? ctr_blk : '0;
            o_mask      <= do_data ? mask_cur : '0;
            o_len_valid <= (st_q == ST_LEN);
            o_len_block <= (st_q == ST_LEN) ? size_q : '0;
        end
    end

    assign o_ready        = ready_q;
    assign o_h            = h_q;
    assign o_j0           = j0_q;
    assign o_key_schedule = ks_q;

endmodule
